// File: rtl/mul_hilo_unit.sv
// HI/LO product register unit: hands operands to an external combinational
// multiplier, waits a fixed number of cycles for it to settle, then captures the product.
module mul_hilo_unit #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] prod_in,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       accept;
  logic       wr_window;

  assign accept    = (state == IDLE) && start;
  // Direct loads are only allowed while no product is in flight.
  assign wr_window = (state == IDLE) || (state == DONE);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (cnt == CNT_LAST) state_next = CAPTURE;
      CAPTURE: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt   <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else if (accept) begin
      cnt   <= '0;
      mul_a <= a_in;
      mul_b <= b_in;
    end else if (state == SETTLE) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Capture wins over a direct load; the two never coincide because writes
  // are masked outside IDLE/DONE.
  always_ff @(posedge clock) begin
    if (clear) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (state == CAPTURE) begin
      hi_out <= prod_in[63:32];
      lo_out <= prod_in[31:0];
    end else if (wr_window) begin
      if (hi_wr) hi_out <= wr_data;
      if (lo_wr) lo_out <= wr_data;
    end
  end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Self-checking bench for mul_hilo_unit: directed corner cases plus randomized
// multiplies with interfering traffic, against a transaction-level model.
module tb_mul_hilo_unit;

  localparam int SC = 2;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] prod_in;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clock = ~clock;

  mul_hilo_unit #(.SETTLE_CYCLES(SC)) dut (
    .clock(clock), .clear(clear), .start(start), .a_in(a_in), .b_in(b_in),
    .mul_a(mul_a), .mul_b(mul_b), .prod_in(prod_in),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
  );

  // External multiplier stand-in: returns a wrong value until the operands
  // have been stable for SC full cycles, so an early capture is visible.
  logic [63:0] true_prod;
  logic [63:0] last_ops = '0;
  int          age = 100;
  assign true_prod = $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
  assign prod_in   = (age >= SC) ? true_prod : ~true_prod;
  always @(negedge clock) begin
    if ({mul_a, mul_b} !== last_ops) begin
      last_ops <= {mul_a, mul_b};
      age      <= 0;
    end else if (age < 100) begin
      age <= age + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // One multiply; e counts edges after the accepting edge. noisy adds ignored
  // traffic while busy (the first busy cycle always re-pulses start with 100x100
  // and writes LO); idle_wr adds a direct load in the start cycle; done_wr
  // adds a direct load in the DONE cycle.
  task automatic mul_op(input logic [31:0] a, input logic [31:0] b,
                        input bit noisy, input bit idle_wr, input bit done_wr);
    logic [63:0] p;
    logic [31:0] d;
    p = ref_mul(a, b);
    a_in = a; b_in = b; start = 1'b1;
    if (idle_wr) begin
      d = $urandom;
      wr_data = d;
      hi_wr = 1'b1;
      lo_wr = 1'($urandom_range(0, 1));
      exp_hi = d;
      if (lo_wr) exp_lo = d;
    end
    step();
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    for (int e = 0; e <= SC + 3; e++) begin
      if (e > 0) step();
      if (e == SC + 1) begin
        exp_hi = p[63:32];
        exp_lo = p[31:0];
      end
      check($sformatf("busy e%0d", e), 64'(busy), 64'(e <= SC + 1));
      check($sformatf("done e%0d", e), 64'(done), 64'(e == SC + 1));
      check($sformatf("mul_a e%0d", e), 64'(mul_a), 64'(a));
      check($sformatf("mul_b e%0d", e), 64'(mul_b), 64'(b));
      check($sformatf("hi e%0d", e), 64'(hi_out), 64'(exp_hi));
      check($sformatf("lo e%0d", e), 64'(lo_out), 64'(exp_lo));
      start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
      if (noisy && e <= SC) begin
        a_in = $urandom; b_in = $urandom; wr_data = $urandom;
        start = 1'($urandom_range(0, 1));
        hi_wr = 1'($urandom_range(0, 1));
        lo_wr = 1'($urandom_range(0, 1));
        if (e == 0) begin
          start = 1'b1; a_in = 32'd100; b_in = 32'd100;
          lo_wr = 1'b1; wr_data = 32'hDEADBEEF;
        end
      end
      if (done_wr && e == SC + 1) begin
        d = $urandom;
        wr_data = d;
        hi_wr = 1'($urandom_range(0, 1));
        lo_wr = 1'($urandom_range(0, 1));
        if (hi_wr) exp_hi = d;
        if (lo_wr) exp_lo = d;
      end
    end
  endtask

  task automatic idle_write(input bit wh, input bit wl, input logic [31:0] d);
    hi_wr = wh; lo_wr = wl; wr_data = d;
    if (wh) exp_hi = d;
    if (wl) exp_lo = d;
    step();
    hi_wr = 1'b0; lo_wr = 1'b0;
    check("wr hi", 64'(hi_out), 64'(exp_hi));
    check("wr lo", 64'(lo_out), 64'(exp_lo));
    check("wr busy", 64'(busy), 64'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " hi"}, 64'(hi_out), 64'd0);
    check({tag, " lo"}, 64'(lo_out), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " mul_a"}, 64'(mul_a), 64'd0);
    check({tag, " mul_b"}, 64'(mul_b), 64'd0);
  endtask

  initial begin
    // Reset, with start and writes asserted to confirm clear wins.
    clear = 1'b1; start = 1'b1; hi_wr = 1'b1; lo_wr = 1'b1;
    wr_data = 32'hFFFF_FFFF; a_in = 32'd9; b_in = 32'd9;
    step();
    step();
    check_cleared("reset");
    clear = 1'b0; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    exp_hi = '0; exp_lo = '0;

    // Directed cases; first start lands in the first cycle after clear.
    mul_op(32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    check("3x4 lo", 64'(lo_out), 64'h0000_000C);
    mul_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0);
    check("-1x1 hi", 64'(hi_out), 64'hFFFF_FFFF);
    mul_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    check("min^2 hi", 64'(hi_out), 64'h4000_0000);
    check("min^2 lo", 64'(lo_out), 64'h0000_0000);
    idle_write(1'b1, 1'b0, 32'h1234_5678);
    check("idle hi_wr", 64'(hi_out), 64'h1234_5678);
    mul_op(32'd7, 32'd6, 1'b1, 1'b0, 1'b0);
    check("7x6 lo", 64'(lo_out), 64'h0000_002A);
    mul_op(32'h0001_0000, 32'hFFFF_0000, 1'b0, 1'b1, 1'b0);
    mul_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    idle_write(1'b1, 1'b1, 32'hA5A5_5A5A);

    // Abort: clear in the second SETTLE cycle.
    a_in = 32'd5; b_in = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    check("abort busy", 64'(busy), 64'd1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check_cleared("abort");
    mul_op(32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
    check("after abort lo", 64'(lo_out), 64'd25);

    // Randomized operations with interfering traffic.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      mul_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0)
        idle_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
